// File: rtl/conv_mode_ctrl.sv
// conv_mode_ctrl: frame-synchronous kernel-bank selection for a 3x3 convolution path.
// Button requests are queued and applied only at a frame boundary, after which the
// datapath is held off for FLUSH_LINES lines while the line buffers refill.
module conv_mode_ctrl #(
  parameter int M           = 320,
  parameter int N           = 240,
  parameter int NUM_MODES   = 4,
  parameter int FLUSH_LINES = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [9:0]                   x,
  input  logic [9:0]                   y,
  input  logic                         btn_next,
  input  logic                         btn_bypass,
  output logic [$clog2(NUM_MODES)-1:0] mode,
  output logic                         conv_en,
  output logic                         pix_valid,
  output logic                         frame_start,
  output logic                         pending,
  output logic [7:0]                   frame_cnt
);

  localparam int MODE_W = $clog2(NUM_MODES);
  localparam int LC_W   = $clog2(FLUSH_LINES + 1);

  localparam logic [9:0]        M_L       = 10'(M);
  localparam logic [9:0]        N_L       = 10'(N);
  localparam logic [MODE_W-1:0] LAST_MODE = MODE_W'(NUM_MODES - 1);
  localparam logic [LC_W-1:0]   FL_L      = LC_W'(FLUSH_LINES);

  typedef enum logic [1:0] {RUN, PEND, FLUSH} state_t;

  state_t            state, state_n;
  logic [9:0]        x_q, y_q;
  logic [MODE_W-1:0] mode_n, next_mode, next_mode_n, req_target;
  logic              pend_flag, pend_flag_n;
  logic [LC_W-1:0]   line_cnt, line_cnt_n;
  logic              req, y_step;

  // Wrapping increment through the kernel banks (last bank wraps to bypass).
  function automatic logic [MODE_W-1:0] mode_inc(input logic [MODE_W-1:0] m);
    if (m == LAST_MODE)
      return '0;
    else
      return m + MODE_W'(1);
  endfunction

  assign req = btn_next | btn_bypass;

  // A line step only counts while the previous line was an active one, so the
  // wrap from the last blanking line back to line 0 is never mistaken for a line.
  assign y_step = (y != y_q) && (y_q < N_L);

  // Frame boundary: the scan arrives at the origin; holding there does not re-fire.
  assign frame_start = !rst && (x == '0) && (y == '0) && ((x_q != '0) || (y_q != '0));

  // Stage 0 -> next-state: mode sequencing, request queueing and flush tracking.
  always_comb begin
    state_n     = state;
    mode_n      = mode;
    next_mode_n = next_mode;
    pend_flag_n = pend_flag;
    line_cnt_n  = line_cnt;
    req_target  = '0;
    case (state)
      RUN: begin
        // bypass outranks next when both arrive together
        req_target = btn_bypass ? '0 : mode_inc(mode);
        if (req && (req_target != mode)) begin
          next_mode_n = req_target;
          state_n     = PEND;
        end
      end
      PEND: begin
        req_target = btn_bypass ? '0 : mode_inc(next_mode);
        if (req)
          next_mode_n = req_target;
        // a request landing on the boundary cycle is folded into this switch
        if (frame_start) begin
          mode_n      = next_mode_n;
          line_cnt_n  = '0;
          pend_flag_n = 1'b0;
          state_n     = FLUSH;
        end
      end
      FLUSH: begin
        req_target = btn_bypass ? '0 : mode_inc(next_mode);
        if (req) begin
          next_mode_n = req_target;
          pend_flag_n = 1'b1;
        end
        if (y_step)
          line_cnt_n = line_cnt + LC_W'(1);
        if (line_cnt_n == FL_L) begin
          state_n     = pend_flag_n ? PEND : RUN;
          pend_flag_n = 1'b0;
        end
      end
      default: state_n = RUN;
    endcase
  end

  // Stage 0 -> 1: state, mode and registered outputs; outputs follow the next state
  // so the datapath is gated on the very first pixel of a flush frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= RUN;
      mode      <= '0;
      next_mode <= '0;
      pend_flag <= 1'b0;
      line_cnt  <= '0;
      conv_en   <= 1'b0;
      pix_valid <= 1'b0;
      pending   <= 1'b0;
      frame_cnt <= 8'd0;
      x_q       <= '0;
      y_q       <= '0;
    end else begin
      state     <= state_n;
      mode      <= mode_n;
      next_mode <= next_mode_n;
      pend_flag <= pend_flag_n;
      line_cnt  <= line_cnt_n;
      conv_en   <= (mode_n != '0) && (state_n != FLUSH);
      pix_valid <= (x < M_L) && (y < N_L) && (state_n != FLUSH);
      pending   <= (state_n == PEND) || ((state_n == FLUSH) && pend_flag_n);
      x_q       <= x;
      y_q       <= y;
      if (frame_start)
        frame_cnt <= frame_cnt + 8'd1;
    end
  end

endmodule

// File: doc/conv_mode_ctrl.md
CONV_MODE_CTRL -- requirements
Module: conv_mode_ctrl

Interface
REQ-001 Parameters SHALL be:
- M, 320: active image width in pixels.
- N, 240: active image height in lines.
- NUM_MODES, 4: number of filter modes (0 = bypass, 1..NUM_MODES-1 = kernel banks).
- FLUSH_LINES, 2: lines conv_en is held low after a mode change, to refill the 3x3 line buffers.
REQ-002 Ports SHALL be:
- clk  in  1  single system clock; all logic on its rising edge.
- rst  in  1  synchronous, active-high reset.
- x  in  10  scan column from the display timing counter; may hold for several clk cycles.
- y  in  10  scan line from the display timing counter.
- btn_next  in  1  single-cycle pulse (already debounced); request the next mode.
- btn_bypass  in  1  single-cycle pulse; request mode 0.
- mode  out  $clog2(NUM_MODES)  active kernel-bank select.
- conv_en  out  1  drives the convolution datapath switch input.
- pix_valid  out  1  current (x,y) is an active, filtered pixel.
- frame_start  out  1  one-cycle pulse at each frame start.
- pending  out  1  a mode change is waiting for a frame boundary.
- frame_cnt  out  8  count of frames since reset.

Function
REQ-003 The block SHALL register x and y as x_q and y_q every cycle.
REQ-004 frame_start SHALL pulse for exactly one cycle when (x,y)==(0,0) and (x_q,y_q)!=(0,0); it SHALL NOT re-fire while (x,y) holds at (0,0).
REQ-005 frame_cnt SHALL increment on each frame_start and wrap from 255 to 0.
REQ-006 The FSM SHALL have three states: RUN, PEND and FLUSH; the reset state SHALL be RUN.
REQ-007 In RUN, btn_next SHALL load next_mode = (mode+1) mod NUM_MODES and move to PEND.
REQ-008 In RUN, btn_bypass SHALL load next_mode = 0 and move to PEND.
REQ-009 In RUN, a request whose target equals the current mode SHALL be ignored, and the FSM SHALL stay in RUN.
REQ-010 In PEND, a further btn_next SHALL set next_mode = (next_mode+1) mod NUM_MODES; btn_bypass SHALL set next_mode = 0; the latest request wins.
REQ-011 When btn_next and btn_bypass are asserted in the same cycle, btn_bypass SHALL take priority.
REQ-012 PEND to FLUSH SHALL occur on the frame_start cycle; on that cycle mode SHALL load next_mode and the line counter SHALL clear.
REQ-013 A request arriving on the same cycle as frame_start while in PEND SHALL be applied in that transition.
REQ-014 A request arriving on the same cycle as frame_start while in RUN SHALL enter PEND and wait for the following frame.
REQ-015 In FLUSH, the line counter SHALL increment once per y change (y != y_q) while y_q < N.
REQ-016 FLUSH SHALL return to RUN on the cycle the line counter reaches FLUSH_LINES.
REQ-017 Requests in FLUSH SHALL update next_mode and set a sticky pend flag; the FSM SHALL go to PEND instead of RUN when FLUSH ends with that flag set.
REQ-018 pending SHALL be high in PEND, and in FLUSH when the pend flag is set; it SHALL be low otherwise.
REQ-019 conv_en SHALL be registered and equal (mode != 0) and (state != FLUSH); it SHALL fall on the cycle after mode loads.
REQ-020 pix_valid SHALL be registered, one cycle after x and y: high when x < M, y < N and the state is not FLUSH.
REQ-021 mode SHALL change only on frame_start cycles; there SHALL be no mid-frame kernel switch.

Reset
REQ-022 While rst is high, the following SHALL be forced: state = RUN, mode = 0, next_mode = 0, pend flag = 0, conv_en = 0, pix_valid = 0, frame_start = 0, pending = 0, frame_cnt = 0, x_q = y_q = 0.
REQ-023 Reset asserted in PEND or FLUSH SHALL discard the queued request; on the first cycle after rst falls, the outputs SHALL hold the REQ-022 values.

Verification
REQ-024 The bench SHALL cover these directed scenarios:
- Reset, then scan 2 frames with no buttons: mode = 0, conv_en = 0, frame_cnt = 2, pix_valid high for exactly 320x240 pixels per frame.
- btn_next mid-frame: pending = 1 until the next frame_start; then mode = 1 and conv_en stays 0 through lines 0..1; conv_en = 1 from line 2 onward.
- Three btn_next pulses within one frame, starting from mode 0: a single transition to mode 3 at the next frame_start; frame_cnt increments once.
- btn_next and btn_bypass in the same cycle while in mode 2: next_mode = 0; after the next frame_start, mode = 0 and conv_en = 0.
- btn_next coincident with frame_start in RUN: mode is unchanged this frame and changes at the following frame_start; a btn_next during FLUSH yields PEND, then a mode increment one frame later.
- rst pulse while pending = 1: mode = 0, pending = 0, frame_cnt = 0; no mode change at the next frame_start.
